// File: rtl/atm_keypad_encoder_pkg.sv
// Shared definitions for the ATM keypad front-end: key codes, session states and
// transaction-type encodings that are also used by the ATM controller.
package atm_keypad_encoder_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam logic [3:0] KEY_DEP    = 4'hD;
    localparam logic [3:0] KEY_RET    = 4'hE;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    // Shared between PIN digits and amount digits; amount use saturates.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PIN         = 3'd1,
        ST_PIN_WAIT    = 3'd2,
        ST_SEL_TRANS   = 3'd3,
        ST_MONTO_ENTRY = 3'd4,
        ST_MONTO_SEND  = 3'd5
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_strobe_gen.sv
// Loadable down-counter producing a STB_CYCLES-wide strobe; clr aborts a pulse
// in progress and takes priority over load.
module atm_strobe_gen #(
    parameter int STB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    output logic stb,
    output logic busy
);

    localparam logic [2:0] LOAD_VAL = 3'(STB_CYCLES);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 3'd0;
        end else if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stb  = (cnt_q != 3'd0);
    assign busy = stb;

endmodule

// File: rtl/atm_keypad_encoder.sv
// ATM keypad front-end: turns key events into strobed PIN digits, a transaction
// type and a binary amount, sequencing the session on the controller's PIN verdict.
module atm_keypad_encoder
    import atm_keypad_encoder_pkg::*;
#(
    parameter int STB_CYCLES = 1,
    parameter int PIN_LEN    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TARJETA_RECIBIDA,
    input  logic        KEY_VALID,
    input  logic [3:0]  KEY_CODE,
    input  logic        PIN_ACEPTADO,
    input  logic        PIN_INCORRECTO,
    output logic [3:0]  DIGITO,
    output logic        DIGITO_STB,
    output logic        TIPO_TRANS,
    output logic [31:0] MONTO,
    output logic        MONTO_STB,
    output logic        KEY_READY,
    output logic        ERROR,
    output state_e      dbg_state
);

    localparam logic [CNT_W-1:0] PIN_LEN_C = CNT_W'(PIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Handshake: a key is taken on a rising CLK edge when KEY_VALID && KEY_READY;
    // otherwise it is dropped. CANCEL is the one exception and aborts any
    // non-IDLE session even while a strobe is running.

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         digito_q, digito_d;
    logic               tipo_q, tipo_d;
    logic [31:0]        monto_q, monto_d;
    logic               error_q, error_d;
    logic               dig_load, dig_clr, dig_busy, dig_stb;
    logic               mon_load, mon_clr, mon_busy, mon_stb;
    logic               key_ready;
    logic               key_acc;
    logic               cancel;
    logic [35:0]        prod;

    atm_strobe_gen #(.STB_CYCLES(STB_CYCLES)) u_dig_stb (
        .clk  (CLK),
        .rst  (RESET),
        .load (dig_load),
        .clr  (dig_clr),
        .stb  (dig_stb),
        .busy (dig_busy)
    );

    atm_strobe_gen #(.STB_CYCLES(STB_CYCLES)) u_mon_stb (
        .clk  (CLK),
        .rst  (RESET),
        .load (mon_load),
        .clr  (mon_clr),
        .stb  (mon_stb),
        .busy (mon_busy)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            digito_q <= 4'd0;
            tipo_q   <= TIPO_DEPOSITO;
            monto_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            digito_q <= digito_d;
            tipo_q   <= tipo_d;
            monto_q  <= monto_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        digito_d = digito_q;
        tipo_d   = tipo_q;
        monto_d  = monto_q;
        error_d  = 1'b0;
        dig_load = 1'b0;
        dig_clr  = 1'b0;
        mon_load = 1'b0;
        mon_clr  = 1'b0;
        key_acc  = KEY_VALID && key_ready;
        cancel   = KEY_VALID && (KEY_CODE == KEY_CANCEL) && (state_q != ST_IDLE);
        prod     = {4'd0, monto_q} * 36'd10 + {32'd0, KEY_CODE};

        case (state_q)
            ST_IDLE: begin
                if (TARJETA_RECIBIDA) begin
                    state_d = ST_PIN;
                    count_d = '0;
                end
            end
            ST_PIN: begin
                if (key_acc && is_digit(KEY_CODE)) begin
                    digito_d = KEY_CODE;
                    count_d  = count_q + 1'b1;
                    dig_load = 1'b1;
                end else if (count_q == PIN_LEN_C && !dig_busy) begin
                    state_d = ST_PIN_WAIT;
                end
            end
            ST_PIN_WAIT: begin
                if (PIN_INCORRECTO) begin
                    state_d = ST_PIN;
                    count_d = '0;
                end else if (PIN_ACEPTADO) begin
                    state_d = ST_SEL_TRANS;
                end
            end
            ST_SEL_TRANS: begin
                if (key_acc && (KEY_CODE == KEY_DEP || KEY_CODE == KEY_RET)) begin
                    tipo_d  = (KEY_CODE == KEY_RET) ? TIPO_RETIRO : TIPO_DEPOSITO;
                    state_d = ST_MONTO_ENTRY;
                    monto_d = 32'd0;
                    count_d = '0;
                end
            end
            ST_MONTO_ENTRY: begin
                if (key_acc) begin
                    if (is_digit(KEY_CODE)) begin
                        // Overflow shows up in the top nibble of the widened product.
                        if (prod[35:32] != 4'd0) begin
                            error_d = 1'b1;
                        end else begin
                            monto_d = prod[31:0];
                            count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                        end
                    end else if (KEY_CODE == KEY_CLEAR) begin
                        monto_d = 32'd0;
                        count_d = '0;
                    end else if (KEY_CODE == KEY_ENTER) begin
                        if (count_q != '0) begin
                            state_d  = ST_MONTO_SEND;
                            mon_load = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
            ST_MONTO_SEND: begin
                if (!mon_busy) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cancel) begin
            state_d  = ST_IDLE;
            monto_d  = 32'd0;
            count_d  = '0;
            error_d  = 1'b0;
            dig_load = 1'b0;
            mon_load = 1'b0;
            dig_clr  = 1'b1;
            mon_clr  = 1'b1;
        end
    end

    always_comb begin
        key_ready = ((state_q == ST_PIN && count_q < PIN_LEN_C) ||
                     state_q == ST_SEL_TRANS || state_q == ST_MONTO_ENTRY) &&
                    !dig_busy && !mon_busy;
        KEY_READY  = key_ready;
        DIGITO     = digito_q;
        DIGITO_STB = dig_stb;
        TIPO_TRANS = tipo_q;
        MONTO      = monto_q;
        MONTO_STB  = mon_stb;
        ERROR      = error_q;
        dbg_state  = state_q;
    end

endmodule
